downmem_responder: RTL and testbench

DOWNMEM_RESPONDER -- requirements
Module: downmem_responder

---
 rtl/cache_def.sv | 20 ++
 rtl/downmem_array.sv | 49 ++++
 rtl/downmem_responder.sv | 137 +++++++++++++
 tb/tb_downmem_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cache_def.sv
// Shared cache/memory handshake types used by the downstream memory responder.
// Types: cache_data_type (128-bit line), mem_req_type, mem_data_type.
package cache_def;

  typedef logic [127:0] cache_data_type;

  typedef struct packed {
    logic           valid;
    logic           rw;
    logic [31:0]    addr;
    logic [31:0]    wraddr;
    cache_data_type data;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;

endpackage

// File: rtl/downmem_array.sv
// Line storage: one registered read port, one write port gated on range.
// Ports: clk, rst (clears read register only), rd_en/rd_addr/rd_data,
// we/wr_addr/wr_data. DOWNMEM_ACCUM_EN makes writes accumulate (old + data).
module downmem_array
  import cache_def::*;
#(
  parameter int DEPTH = 122
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rd_en,
  input  logic [31:0]    rd_addr,
  output cache_data_type rd_data,
  input  logic           we,
  input  logic [31:0]    wr_addr,
  input  cache_data_type wr_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Power-up contents are zero; reset deliberately leaves them alone.
  cache_data_type mem [DEPTH] = '{default: '0};

  logic rd_ok;
  logic wr_ok;

  assign rd_ok = rd_addr < 32'(DEPTH);
  assign wr_ok = we && (wr_addr < 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
`ifdef DOWNMEM_ACCUM_EN
      mem[wr_addr[AW-1:0]] <= mem[wr_addr[AW-1:0]] + wr_data;
`else
      mem[wr_addr[AW-1:0]] <= wr_data;
`endif
    end
  end

  // Out-of-range reads return zero; the register holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_ok ? mem[rd_addr[AW-1:0]] : '0;
    end
  end

endmodule

// File: rtl/downmem_responder.sv
// Fixed-latency downstream memory model answering a cache FSM.
// Ports: clk, rst (sync, active-high), mem_req in, mem_data_down out,
// busy, addr_err. Params DEPTH, RD_LAT, WR_LAT. Macro: DOWNMEM_ACCUM_EN.
module downmem_responder
  import cache_def::*;
#(
  parameter int DEPTH  = 122,
  parameter int RD_LAT = 5,
  parameter int WR_LAT = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data_down,
  output logic         busy,
  output logic         addr_err
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    RESP
  } state_t;

  // The acceptance cycle and RESP cycle bracket LAT-1 wait cycles.
  localparam logic [3:0] RD_LD = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;
  localparam logic [3:0] WR_LD = (WR_LAT > 1) ? 4'(WR_LAT - 2) : 4'd0;

  state_t         state;
  logic [3:0]     cnt;
  logic           rw_q;
  logic [31:0]    addr_q;
  logic [31:0]    wraddr_q;
  cache_data_type data_q;
  logic           ready_q;
  logic           busy_q;
  logic           err_q;

  logic           accept;
  logic           lat_one;
  logic           to_resp;
  logic           cur_rw;
  logic [31:0]    cur_a;
  logic [31:0]    cur_wa;
  logic           err_n;
  logic           rd_en;
  logic           we;
  cache_data_type rd_data;

  always_comb begin
    accept  = (state == IDLE) && mem_req.valid;
    lat_one = mem_req.rw ? (WR_LAT == 1) : (RD_LAT == 1);
    to_resp = (accept && lat_one) ||
              (((state == RD_WAIT) || (state == WR_WAIT)) && (cnt == 4'd0));
    // A latency-1 request reaches RESP straight from IDLE,
    // so it must use the live request rather than the capture.
    cur_rw  = accept ? mem_req.rw     : rw_q;
    cur_a   = accept ? mem_req.addr   : addr_q;
    cur_wa  = accept ? mem_req.wraddr : wraddr_q;
    err_n   = cur_rw ? (cur_wa >= 32'(DEPTH)) : (cur_a >= 32'(DEPTH));
    rd_en   = to_resp && !cur_rw && !rst;
    we      = (state == RESP) && rw_q && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wraddr_q <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_req.valid) begin
            rw_q     <= mem_req.rw;
            addr_q   <= mem_req.addr;
            wraddr_q <= mem_req.wraddr;
            data_q   <= mem_req.data;
            busy_q   <= 1'b1;
            if (lat_one) begin
              state   <= RESP;
              ready_q <= 1'b1;
              err_q   <= err_n;
            end else begin
              state <= mem_req.rw ? WR_WAIT : RD_WAIT;
              cnt   <= mem_req.rw ? WR_LD : RD_LD;
            end
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (cnt == 4'd0) begin
            state   <= RESP;
            ready_q <= 1'b1;
            err_q   <= err_n;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  downmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (rd_en),
    .rd_addr(cur_a),
    .rd_data(rd_data),
    .we     (we),
    .wr_addr(wraddr_q),
    .wr_data(data_q)
  );

  always_comb begin
    mem_data_down.data  = rd_data;
    mem_data_down.ready = ready_q;
  end

  assign busy     = busy_q;
  assign addr_err = err_q;

endmodule

// File: tb/tb_downmem_responder.sv
// Randomized self-checking bench for downmem_responder.
// Reference: line array plus fixed-latency timing rules.
module tb_downmem_responder;
  import cache_def::*;

  localparam int DEPTH  = 122;
  localparam int RD_LAT = 5;
  localparam int WR_LAT = 7;

  logic         clk = 1'b0;
  logic         rst;
  mem_req_type  mem_req;
  mem_data_type mem_data_down;
  logic         busy;
  logic         addr_err;

  int checks = 0;
  int errors = 0;

  cache_data_type m [DEPTH];

  downmem_responder #(
    .DEPTH (DEPTH),
    .RD_LAT(RD_LAT),
    .WR_LAT(WR_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_data_down(mem_data_down),
    .busy         (busy),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic cache_data_type rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic cache_data_type model_rd(input logic [31:0] a);
    return (a < DEPTH) ? m[a] : '0;
  endfunction

  task automatic model_wr(input logic [31:0] a, input cache_data_type d);
    if (a < DEPTH) begin
`ifdef DOWNMEM_ACCUM_EN
      m[a] = m[a] + d;
`else
      m[a] = d;
`endif
    end
  endtask

  // One full transaction from an idle DUT, inputs scrambled after accept.
  task automatic xact(input logic rw, input logic [31:0] a,
                      input cache_data_type d);
    int n;
    int lat;
    cache_data_type exp;
    lat = rw ? WR_LAT : RD_LAT;
    exp = model_rd(a);
    @(negedge clk);
    mem_req.valid  = 1'b1;
    mem_req.rw     = rw;
    mem_req.addr   = a;
    mem_req.wraddr = a;
    mem_req.data   = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        mem_req.valid  = 1'b0;
        mem_req.rw     = 1'($urandom);
        mem_req.addr   = $urandom_range(0, 200);
        mem_req.wraddr = $urandom_range(0, 200);
        mem_req.data   = rnd128();
      end
    end while (!mem_data_down.ready && n < 40);
    check("latency", 128'(n), 128'(lat));
    check("addr_err", 128'(addr_err), 128'(a >= DEPTH));
    if (!rw) check("rdata", mem_data_down.data, exp);
    else model_wr(a, d);
    @(negedge clk);
    check("ready_one_cycle", 128'(mem_data_down.ready), 128'(0));
    check("idle_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    int ones_a;
    logic [31:0] addrs [30];
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
    mem_req = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 128'(mem_data_down.ready), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_err", 128'(addr_err), 128'(0));
    check("rst_data", mem_data_down.data, 128'(0));
    rst = 1'b0;

    xact(1'b0, 32'd3, '0);
    xact(1'b1, 32'd3, 128'h10);
    xact(1'b1, 32'd3, 128'h05);
    xact(1'b0, 32'd3, '0);
    xact(1'b1, 32'd7, '1);
    xact(1'b1, 32'd7, 128'h2);
    xact(1'b0, 32'd7, '0);
    xact(1'b0, 32'd122, '0);
    xact(1'b1, 32'd200, 128'h9);

    // Abandon a write by resetting 3 cycles after acceptance.
    xact(1'b1, 32'd5, 128'h1234);
    @(negedge clk);
    mem_req.valid  = 1'b1;
    mem_req.rw     = 1'b1;
    mem_req.addr   = 32'd5;
    mem_req.wraddr = 32'd5;
    mem_req.data   = 128'h40;
    @(negedge clk);
    mem_req.valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 128'(busy), 128'(0));
    ones_a = 0;
    repeat (12) begin
      @(negedge clk);
      if (mem_data_down.ready) ones_a++;
    end
    check("no_ready_after_rst", 128'(ones_a), 128'(0));
    xact(1'b0, 32'd5, '0);

    // Reset wins over a simultaneous valid request.
    @(negedge clk);
    rst = 1'b1;
    mem_req.valid = 1'b1;
    mem_req.rw    = 1'b0;
    mem_req.addr  = 32'd1;
    @(negedge clk);
    rst = 1'b0;
    mem_req.valid = 1'b0;
    check("rst_prio_busy", 128'(busy), 128'(0));
    @(negedge clk);
    check("rst_prio_idle", 128'(busy), 128'(0));

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) a = 32'(DEPTH + $urandom_range(0, 20));
      else a = $urandom_range(0, 15);
      xact(1'($urandom), a, rnd128());
    end

    // Valid held high: one accept per RD_LAT+1 cycles, inputs churn.
    for (int i = 0; i < 30; i++) addrs[i] = $urandom_range(0, 125);
    for (int rel = 0; rel < 30; rel++) begin
      @(negedge clk);
      if (rel > 0) begin
        check("cont_busy", 128'(busy), 128'((rel % (RD_LAT + 1)) != 0));
        check("cont_ready", 128'(mem_data_down.ready),
              128'((rel % (RD_LAT + 1)) == RD_LAT));
        if ((rel % (RD_LAT + 1)) == RD_LAT) begin
          check("cont_data", mem_data_down.data,
                model_rd(addrs[rel - RD_LAT]));
          check("cont_err", 128'(addr_err),
                128'(addrs[rel - RD_LAT] >= DEPTH));
        end
      end
      mem_req.valid  = 1'b1;
      mem_req.rw     = 1'b0;
      mem_req.addr   = addrs[rel];
      mem_req.wraddr = $urandom_range(0, 121);
      mem_req.data   = rnd128();
    end
    @(negedge clk);
    mem_req.valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) xact(1'b0, 32'(i), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
